iir_tdm_filter: RTL and testbench
=================================

// Module: iir_tdm_filter
// PURPOSE
//  Parametrised direct-form-I IIR filter with runtime-loadable coefficients and a single time-multiplexed MAC.
//  Streams samples from sample memory (load/RAddr/DIn) and writes results to result memory (WEN/WAddr/Yn).
//  Replaces fixed-coefficient shift-add filters. One engine serves any order up to ORDER.
// PARAMETERS
//  DW     16  sample/result width, signed two's complement
//  CW     20  coefficient width, signed
//  FRAC   16  coefficient fractional bits (1.0 = 1<<FRAC)
//  ORDER  4   filter order; NTAP = 2*ORDER+1 coefficients
//  AW     20  memory address width
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset, asynchronous, active-high
//  start      in   1          1-cycle pulse; begins run from address 0 (ignored unless IDLE/DONE)
//  cfg_we     in   1          coefficient write strobe (accepted only in IDLE/DONE)
//  cfg_addr   in   clog2(NTAP) 0..ORDER -> b[k]; ORDER+1..2*ORDER -> a[k-ORDER]
//  cfg_data   in   CW         coefficient value
//  load       out  1          sample-memory read enable
//  RAddr      out  AW         sample read address
//  DIn        in   DW         sample data, valid the cycle after load
//  data_done  in   1          level: no sample exists at RAddr
//  WEN        out  1          result write strobe, 1 cycle
//  WAddr      out  AW         result address (= sample index)
//  Yn         out  DW         result data
//  Finish     out  1          sticky run-complete flag
//  busy       out  1          high in FETCH/CAPT/MAC/WRITE
//  ovf        out  1          sticky saturation flag (0 when IIR_SAT_EN undefined)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; x/y history and all coefficients cleared to 0.
//  y[n] = sum_{k=0..ORDER} b[k]*x[n-k] - sum_{k=1..ORDER} a[k]*y[n-k].
//  FSM: IDLE -start-> FETCH; DONE -start-> FETCH (Finish cleared, history cleared, RAddr=0).
//   FETCH: if data_done -> DONE (Finish=1, busy=0); else load=1 -> CAPT.
//   CAPT: x history shifts in DIn; RAddr+=1 -> MAC.
//   MAC: NTAP cycles, one product/cycle, order b0..bORDER then a1..aORDER -> WRITE.
//   WRITE: WEN=1, WAddr=RAddr-1, Yn=result; y history shifts in result -> FETCH.
//  Per-sample cadence 2*ORDER+4 cycles (12 at default); Yn/WAddr hold between WRITEs.
//  Accumulator ACC_W = DW+CW+clog2(NTAP), no internal overflow.
//  Result: (acc + (1<<(FRAC-1))) >>> FRAC (round half up), then fit to DW.
//  Feedback uses the DW-bit result written to Yn, not the accumulator.
//  RAddr wraps 2^AW-1 -> 0 without stopping; data_done alone ends a run.
//  start while busy ignored; cfg_we while busy ignored, coefficients unchanged.
//  rst mid-run: immediate abort to reset state; no partial WEN.
// CONFIGURATION
//  IIR_SAT_EN defined: result clamped to [-2^(DW-1), 2^(DW-1)-1]; any clamp sets ovf until start/rst.
//  Undefined: result keeps low DW bits (wraps); ovf tied 0.
// STRUCTURE
//  Package iir_pkg: state enum (IDLE,FETCH,CAPT,MAC,WRITE,DONE), acc_w() function, tap-index typedef.
//  Sub-module iir_mac: signed multiply, accumulate, clear, round, saturate/wrap.
//  Top: FSM, tap counter, address counters, coefficient regfile, x/y history shift registers.
// TESTING
//  1 b0=65536, rest 0; x=[100,-5,32767] -> Yn=[100,-5,32767], WAddr 0,1,2, WEN every 12 cycles.
//  2 b1=65536 only; x=[100,200,300] -> Yn=[0,100,200].
//  3 b0=65536, a1=-32768; x=[16384,0,0,0] -> Yn=[16384,8192,4096,2048].
//  4 b0=131072; x=20000 -> SAT_EN: Yn=32767, ovf=1; no macro: Yn=-25536, ovf=0.
//  5 data_done rises when RAddr=3 -> exactly 3 WEN pulses, Finish=1, busy=0; start -> rerun from 0.
//  6 rst mid-MAC, cfg_we while busy -> all outputs 0, coefficients 0; busy-time write has no effect.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared types for the time-multiplexed IIR engine: FSM states, tap index and
// accumulator sizing.
package iir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    MAC,
    WRITE,
    DONE
  } state_t;

  // Wide enough for any ORDER up to 127 (NTAP <= 255).
  typedef logic [7:0] tap_t;

  // Headroom for NTAP full-scale products summed without overflow.
  function automatic int acc_w(input int dw, input int cw, input int ntap);
    return dw + cw + $clog2(ntap);
  endfunction

endpackage

// File: rtl/iir_mac.sv
// Single multiply-accumulate unit with round-half-up output stage.
// IIR_SAT_EN: clamp the rounded result to DW bits and flag it; otherwise wrap.
module iir_mac
  import iir_pkg::*;
#(
  parameter int DW   = 16,
  parameter int CW   = 20,
  parameter int FRAC = 16,
  parameter int NTAP = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 vld_p0,
  input  logic                 sub_p0,
  input  logic signed [CW-1:0] coef_p0,
  input  logic signed [DW-1:0] data_p0,
  output logic signed [DW-1:0] result,
  output logic                 clamp
);

  localparam int ACC_W = acc_w(DW, CW, NTAP);
  localparam int RW    = ACC_W + 1;

  logic signed [CW+DW-1:0] prod_p0;
  logic signed [ACC_W-1:0] acc_p1;

  function automatic logic signed [RW-1:0] round_half_up(input logic signed [ACC_W-1:0] a);
    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] half;
    ext  = {a[ACC_W-1], a};
    half = '0;
    half[FRAC-1] = 1'b1;
    return (ext + half) >>> FRAC;
  endfunction

`ifdef IIR_SAT_EN
  localparam logic signed [RW-1:0] Y_MAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] Y_MIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [DW-1:0] fit(input logic signed [RW-1:0] r);
    if (r > Y_MAX) return Y_MAX[DW-1:0];
    if (r < Y_MIN) return Y_MIN[DW-1:0];
    return r[DW-1:0];
  endfunction

  function automatic logic clamped(input logic signed [RW-1:0] r);
    return (r > Y_MAX) || (r < Y_MIN);
  endfunction
`else
  function automatic logic signed [DW-1:0] fit(input logic signed [RW-1:0] r);
    return r[DW-1:0];
  endfunction

  function automatic logic clamped(input logic signed [RW-1:0] r);
    return r[0] & 1'b0;
  endfunction
`endif

  assign prod_p0 = coef_p0 * data_p0;

  // p0 -> p1: accumulate one product per cycle; feedback taps subtract.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p1 <= '0;
    end else if (clr) begin
      acc_p1 <= '0;
    end else if (vld_p0) begin
      acc_p1 <= sub_p0 ? acc_p1 - ACC_W'(prod_p0) : acc_p1 + ACC_W'(prod_p0);
    end
  end

  assign result = fit(round_half_up(acc_p1));
  assign clamp  = clamped(round_half_up(acc_p1));

endmodule

// File: rtl/iir_tdm_filter.sv
// Direct-form-I IIR filter with loadable coefficients sharing one MAC across taps.
// Optional IIR_SAT_EN (in iir_mac) selects saturating output and the sticky ovf flag.
module iir_tdm_filter
  import iir_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = 20,
  parameter int FRAC  = 16,
  parameter int ORDER = 4,
  parameter int AW    = 20
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               cfg_we,
  input  logic [$clog2(2*ORDER+1)-1:0]       cfg_addr,
  input  logic signed [CW-1:0]               cfg_data,
  output logic                               load,
  output logic [AW-1:0]                      RAddr,
  input  logic signed [DW-1:0]               DIn,
  input  logic                               data_done,
  output logic                               WEN,
  output logic [AW-1:0]                      WAddr,
  output logic signed [DW-1:0]               Yn,
  output logic                               Finish,
  output logic                               busy,
  output logic                               ovf
);

  localparam int NTAP = 2*ORDER + 1;
  localparam int CAW  = $clog2(NTAP);

  state_t               state_q;
  tap_t                 tap_q;
  logic [AW-1:0]        raddr_q;
  logic [AW-1:0]        waddr_q;
  logic signed [DW-1:0] yn_q;
  logic                 finish_q;
  logic                 ovf_q;

  logic signed [CW-1:0] coef_q [NTAP];
  logic signed [DW-1:0] x_hist [ORDER+1];
  logic signed [DW-1:0] y_hist [ORDER];

  logic signed [CW-1:0] mac_coef_p0;
  logic signed [DW-1:0] mac_data_p0;
  logic                 mac_sub_p0;
  logic                 vld_p0;
  logic signed [DW-1:0] mac_result;
  logic                 mac_clamp;
  logic                 idle_w;

  assign idle_w = (state_q == IDLE) || (state_q == DONE);
  assign vld_p0 = (state_q == MAC);

  // Tap order: b0..bORDER against x history, then a1..aORDER against y history.
  always_comb begin
    mac_coef_p0 = '0;
    mac_data_p0 = '0;
    mac_sub_p0  = 1'b0;
    for (int k = 0; k <= ORDER; k++) begin
      if (tap_q == tap_t'(k)) begin
        mac_coef_p0 = coef_q[k];
        mac_data_p0 = x_hist[k];
      end
    end
    for (int k = 1; k <= ORDER; k++) begin
      if (tap_q == tap_t'(ORDER + k)) begin
        mac_coef_p0 = coef_q[ORDER + k];
        mac_data_p0 = y_hist[k-1];
        mac_sub_p0  = 1'b1;
      end
    end
  end

  iir_mac #(
    .DW   (DW),
    .CW   (CW),
    .FRAC (FRAC),
    .NTAP (NTAP)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == CAPT),
    .vld_p0  (vld_p0),
    .sub_p0  (mac_sub_p0),
    .coef_p0 (mac_coef_p0),
    .data_p0 (mac_data_p0),
    .result  (mac_result),
    .clamp   (mac_clamp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAP; k++) coef_q[k] <= '0;
    end else if (cfg_we && idle_w) begin
      for (int k = 0; k < NTAP; k++) begin
        if (cfg_addr == CAW'(k)) coef_q[k] <= cfg_data;
      end
    end
  end

  // Feedback history holds the DW-bit result as written, not the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= ORDER; k++) x_hist[k] <= '0;
      for (int k = 0; k < ORDER; k++) y_hist[k] <= '0;
    end else if (start && idle_w) begin
      for (int k = 0; k <= ORDER; k++) x_hist[k] <= '0;
      for (int k = 0; k < ORDER; k++) y_hist[k] <= '0;
    end else if (state_q == CAPT) begin
      x_hist[0] <= DIn;
      for (int k = 1; k <= ORDER; k++) x_hist[k] <= x_hist[k-1];
    end else if (state_q == WRITE) begin
      y_hist[0] <= mac_result;
      for (int k = 1; k < ORDER; k++) y_hist[k] <= y_hist[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tap_q    <= '0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      yn_q     <= '0;
      finish_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= FETCH;
            finish_q <= 1'b0;
            ovf_q    <= 1'b0;
            raddr_q  <= '0;
          end
        end
        FETCH: begin
          if (data_done) begin
            state_q  <= DONE;
            finish_q <= 1'b1;
          end else begin
            state_q <= CAPT;
          end
        end
        CAPT: begin
          raddr_q <= raddr_q + AW'(1);
          tap_q   <= '0;
          state_q <= MAC;
        end
        MAC: begin
          if (tap_q == tap_t'(NTAP - 1)) state_q <= WRITE;
          else                           tap_q   <= tap_q + tap_t'(1);
        end
        WRITE: begin
          yn_q    <= mac_result;
          waddr_q <= raddr_q - AW'(1);
          if (mac_clamp) ovf_q <= 1'b1;
          state_q <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load   = (state_q == FETCH) && !data_done;
  assign RAddr  = raddr_q;
  assign WEN    = (state_q == WRITE);
  assign WAddr  = (state_q == WRITE) ? raddr_q - AW'(1) : waddr_q;
  assign Yn     = (state_q == WRITE) ? mac_result : yn_q;
  assign Finish = finish_q;
  assign busy   = (state_q == FETCH) || (state_q == CAPT) || (state_q == MAC) || (state_q == WRITE);
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_iir_tdm_filter.sv
// Self-checking bench for iir_tdm_filter: fixed and random streams against a
// difference-equation model, run/rerun control, busy-time writes and reset abort.
module tb_iir_tdm_filter;

  localparam int DW = 16, CW = 20, FRAC = 16, ORDER = 4, AW = 20;
  localparam int NTAP = 2*ORDER + 1;
  localparam int CADENCE = 2*ORDER + 4;

  logic                 clk = 1'b0;
  logic                 rst, start, cfg_we, load, data_done, WEN, Finish, busy, ovf;
  logic [3:0]           cfg_addr;
  logic signed [CW-1:0] cfg_data;
  logic [AW-1:0]        RAddr, WAddr;
  logic signed [DW-1:0] DIn, Yn;

  iir_tdm_filter #(.DW(DW), .CW(CW), .FRAC(FRAC), .ORDER(ORDER), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .load(load), .RAddr(RAddr), .DIn(DIn), .data_done(data_done),
    .WEN(WEN), .WAddr(WAddr), .Yn(Yn), .Finish(Finish), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  longint mem [64];
  int     n_samp = 0;
  longint cb [NTAP];
  longint exp_y [64];
  bit     exp_ovf;
  int     vectors = 0, errors = 0, cyc = 0;
  logic signed [DW-1:0] yq [$];
  logic [AW-1:0]        aq [$];
  int                   cq [$];

  longint tc_coef [4][NTAP] = '{'{65536, 0, 0, 0, 0, 0, 0, 0, 0},
                                '{0, 65536, 0, 0, 0, 0, 0, 0, 0},
                                '{65536, 0, 0, 0, 0, -32768, 0, 0, 0},
                                '{131072, 0, 0, 0, 0, 0, 0, 0, 0}};
  longint tc_x [4][4] = '{'{100, -5, 32767, 0}, '{100, 200, 300, 0},
                          '{16384, 0, 0, 0}, '{20000, 0, 0, 0}};
  int     tc_n [4] = '{3, 3, 4, 1};
`ifdef IIR_SAT_EN
  longint tc_y [4][4] = '{'{100, -5, 32767, 0}, '{0, 100, 200, 0},
                          '{16384, 8192, 4096, 2048}, '{32767, 0, 0, 0}};
  bit     tc_ovf [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
  longint tc_y [4][4] = '{'{100, -5, 32767, 0}, '{0, 100, 200, 0},
                          '{16384, 8192, 4096, 2048}, '{-25536, 0, 0, 0}};
  bit     tc_ovf [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (WEN) begin
      yq.push_back(Yn);
      aq.push_back(WAddr);
      cq.push_back(cyc);
    end
  end

  // Sample memory: data present from the address cycle onward, done past the end.
  always_comb begin
    data_done = (RAddr >= AW'(n_samp));
    DIn = data_done ? '0 : DW'(mem[RAddr[5:0]]);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // y[n] = sum b[k] x[n-k] - sum a[k] y[n-k], rounded half up, fitted to DW bits.
  function automatic void model_run(input int n);
    longint acc, r;
    exp_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = 0;
      for (int k = 0; k <= ORDER; k++) if (i - k >= 0) acc += cb[k] * mem[i-k];
      for (int k = 1; k <= ORDER; k++) if (i - k >= 0) acc -= cb[ORDER+k] * exp_y[i-k];
      r = (acc + (longint'(1) << (FRAC-1))) >>> FRAC;
`ifdef IIR_SAT_EN
      if (r > 32767) begin r = 32767; exp_ovf = 1'b1; end
      else if (r < -32768) begin r = -32768; exp_ovf = 1'b1; end
`else
      r = r & 65535;
      if (r >= 32768) r -= 65536;
`endif
      exp_y[i] = r;
    end
  endfunction

  task automatic cfg_write(input int addr, input longint val);
    cfg_addr = 4'(addr);
    cfg_data = CW'(val);
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic load_coefs(input longint c [NTAP]);
    for (int k = 0; k < NTAP; k++) begin
      cfg_write(k, c[k]);
      cb[k] = c[k];
    end
  endtask

  task automatic wait_finish(input int budget, output bit ok);
    int c = 0;
    while (!Finish && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    ok = Finish;
  endtask

  task automatic run_capture(input int budget, output bit ok);
    yq.delete(); aq.delete(); cq.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_finish(budget, ok);
  endtask

  task automatic test_reset();
    vectors++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b want 0", load); end
    vectors++; if (RAddr !== '0) begin errors++; $display("FAIL reset_raddr: got %0h want 0", RAddr); end
    vectors++; if (WEN !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", WEN); end
    vectors++; if (WAddr !== '0) begin errors++; $display("FAIL reset_waddr: got %0h want 0", WAddr); end
    vectors++; if (Yn !== '0) begin errors++; $display("FAIL reset_yn: got %0d want 0", Yn); end
    vectors++; if (Finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b want 0", Finish); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_fixed_vectors();
    longint co [NTAP];
    bit ok;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < NTAP; k++) co[k] = tc_coef[t][k];
      load_coefs(co);
      for (int i = 0; i < 4; i++) mem[i] = tc_x[t][i];
      n_samp = tc_n[t];
      run_capture(400, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL fixed%0d_finish: got %b want 1", t, Finish); end
      vectors++;
      if (yq.size() != tc_n[t]) begin
        errors++; $display("FAIL fixed%0d_count: got %0d want %0d", t, yq.size(), tc_n[t]);
      end
      for (int i = 0; i < tc_n[t] && i < yq.size(); i++) begin
        vectors++;
        if (yq[i] !== DW'(tc_y[t][i])) begin
          errors++; $display("FAIL fixed%0d_yn[%0d]: got %0d want %0d", t, i, yq[i], tc_y[t][i]);
        end
        vectors++;
        if (aq[i] !== AW'(i)) begin
          errors++; $display("FAIL fixed%0d_waddr[%0d]: got %0d want %0d", t, i, aq[i], i);
        end
        if (i > 0) begin
          vectors++;
          if (cq[i] - cq[i-1] != CADENCE) begin
            errors++; $display("FAIL fixed%0d_cadence[%0d]: got %0d want %0d", t, i, cq[i] - cq[i-1], CADENCE);
          end
        end
      end
      vectors++;
      if (ovf !== tc_ovf[t]) begin
        errors++; $display("FAIL fixed%0d_ovf: got %b want %b", t, ovf, tc_ovf[t]);
      end
    end
  endtask

  task automatic test_random();
    longint co [NTAP];
    bit ok;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < NTAP; k++) co[k] = longint'($signed(20'($urandom))) >>> (2*it);
      load_coefs(co);
      for (int i = 0; i < 10; i++) mem[i] = longint'($signed(16'($urandom)));
      n_samp = 10;
      model_run(10);
      run_capture(400, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL rand%0d_finish: got %b want 1", it, Finish); end
      vectors++;
      if (yq.size() != 10) begin errors++; $display("FAIL rand%0d_count: got %0d want 10", it, yq.size()); end
      for (int i = 0; i < 10 && i < yq.size(); i++) begin
        vectors++;
        if (yq[i] !== DW'(exp_y[i])) begin
          errors++; $display("FAIL rand%0d_yn[%0d]: got %0d want %0d", it, i, yq[i], exp_y[i]);
        end
        vectors++;
        if (aq[i] !== AW'(i)) begin
          errors++; $display("FAIL rand%0d_waddr[%0d]: got %0d want %0d", it, i, aq[i], i);
        end
      end
      vectors++;
      if (ovf !== exp_ovf) begin errors++; $display("FAIL rand%0d_ovf: got %b want %b", it, ovf, exp_ovf); end
    end
  endtask

  task automatic test_done_rerun();
    longint co [NTAP];
    bit ok;
    for (int k = 0; k < NTAP; k++) co[k] = tc_coef[2][k];
    load_coefs(co);
    for (int i = 0; i < 3; i++) mem[i] = longint'($signed(16'($urandom)));
    n_samp = 3;
    model_run(3);
    for (int pass = 0; pass < 2; pass++) begin
      run_capture(400, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL done%0d_finish: got %b want 1", pass, Finish); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL done%0d_busy: got %b want 0", pass, busy); end
      vectors++; if (load !== 1'b0) begin errors++; $display("FAIL done%0d_load: got %b want 0", pass, load); end
      vectors++;
      if (yq.size() != 3) begin errors++; $display("FAIL done%0d_count: got %0d want 3", pass, yq.size()); end
      for (int i = 0; i < 3 && i < yq.size(); i++) begin
        vectors++;
        if (yq[i] !== DW'(exp_y[i]) || aq[i] !== AW'(i)) begin
          errors++;
          $display("FAIL done%0d_sample[%0d]: got %0d@%0d want %0d@%0d", pass, i, yq[i], aq[i], exp_y[i], i);
        end
      end
    end
  endtask

  task automatic test_busy_ignored();
    longint co [NTAP];
    bit ok;
    for (int k = 0; k < NTAP; k++) co[k] = 0;
    co[0] = 65536;
    co[1] = 32768;
    load_coefs(co);
    for (int i = 0; i < 4; i++) mem[i] = longint'($signed(16'($urandom)));
    n_samp = 4;
    model_run(4);
    yq.delete(); aq.delete(); cq.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_flag: got %b want 1", busy); end
    start = 1'b1;
    cfg_write(0, 131072);
    start = 1'b0;
    wait_finish(400, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL busy_finish: got %b want 1", Finish); end
    vectors++;
    if (yq.size() != 4) begin errors++; $display("FAIL busy_count: got %0d want 4", yq.size()); end
    for (int i = 0; i < 4 && i < yq.size(); i++) begin
      vectors++;
      if (yq[i] !== DW'(exp_y[i]) || aq[i] !== AW'(i)) begin
        errors++; $display("FAIL busy_sample[%0d]: got %0d@%0d want %0d@%0d", i, yq[i], aq[i], exp_y[i], i);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    longint co [NTAP];
    bit ok;
    for (int k = 0; k < NTAP; k++) co[k] = 0;
    co[0] = 65536;
    load_coefs(co);
    for (int i = 0; i < 5; i++) mem[i] = 1000 + 7*i;
    n_samp = 5;
    yq.delete(); aq.delete(); cq.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({load, RAddr, WEN, WAddr, Yn, Finish, busy, ovf} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got load=%b raddr=%0h wen=%b waddr=%0h yn=%0d fin=%b busy=%b ovf=%b want all 0",
               load, RAddr, WEN, WAddr, Yn, Finish, busy, ovf);
    end
    vectors++;
    if (yq.size() != 0) begin errors++; $display("FAIL abort_wen: got %0d pulses want 0", yq.size()); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NTAP; k++) cb[k] = 0;
    model_run(5);
    run_capture(400, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL abort_rerun_finish: got %b want 1", Finish); end
    vectors++;
    if (yq.size() != 5) begin errors++; $display("FAIL abort_rerun_count: got %0d want 5", yq.size()); end
    for (int i = 0; i < 5 && i < yq.size(); i++) begin
      vectors++;
      if (yq[i] !== DW'(exp_y[i])) begin
        errors++; $display("FAIL abort_coef_cleared[%0d]: got %0d want %0d", i, yq[i], exp_y[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_fixed_vectors();
    test_random();
    test_done_rerun();
    test_busy_ignored();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
